led_pattern_sched: RTL and testbench

//  Time-shares the 8-bit LED bank between NSRC pattern generators (fibonacci, counter, shift, ...).

---
 rtl/led_sched_pkg.sv | 38 +++
 rtl/tick_prescaler.sv | 27 ++
 rtl/led_pattern_sched.sv | 118 +++++++++++
 tb/tb_led_pattern_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED pattern scheduler: FSM state encoding,
// a constant log2 and the round-robin source search.
package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTART = 2'd1,
    ST_RUN     = 2'd2,
    ST_SWITCH  = 2'd3
  } state_e;

  localparam int MAX_SRC = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // First set bit of mask strictly after idx, wrapping at nsrc; idx itself is
  // the last candidate so a lone valid source reselects itself.
  function automatic logic [2:0] next_valid(input logic [2:0] idx,
                                            input logic [MAX_SRC-1:0] mask,
                                            input int nsrc);
    logic [2:0] res;
    int j;
    res = idx;
    for (int k = nsrc; k >= 1; k--) begin
      j = (int'(idx) + k) % nsrc;
      if (mask[j]) res = j[2:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running decimation counter; tick is high for the single cycle in which
// the count sits at DECIMATION-1.
module tick_prescaler #(
  parameter logic [19:0] DECIMATION = 20'd1000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [19:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    tick    = (count_q == DECIMATION - 20'd1);
    count_d = tick ? '0 : count_q + 20'd1;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/led_pattern_sched.sv
// Round-robin scheduler that time-shares the LED bank between NSRC pattern
// generators, handing each its restart, enable and gated prescaler tick.
module led_pattern_sched
  import led_sched_pkg::*;
#(
  parameter int          NSRC       = 4,
  parameter int          WIDTH      = 8,
  parameter logic [19:0] DECIMATION = 20'd1000000,
  parameter logic [7:0]  DWELL      = 8'd16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NSRC*WIDTH-1:0]     src_data,
  input  logic [NSRC-1:0]           src_valid,
  input  logic                      hold,
  input  logic                      next,
  output logic [NSRC-1:0]           src_restart,
  output logic [NSRC-1:0]           src_enable,
  output logic [NSRC-1:0]           src_tick,
  output logic [clog2(NSRC)-1:0]    active_idx,
  output logic [WIDTH-1:0]          out
);

  localparam int IW = clog2(NSRC);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [7:0]         dwell_q, dwell_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               tick;
  logic [MAX_SRC-1:0] valid_ext;
  logic [IW-1:0]      idx_lowest, idx_rr;
  logic [NSRC-1:0]    idx_onehot;
  logic               active_valid;

  tick_prescaler #(.DECIMATION(DECIMATION)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    valid_ext               = '0;
    valid_ext[NSRC-1:0]     = src_valid;
    idx_lowest              = IW'(next_valid(3'(NSRC - 1), valid_ext, NSRC));
    idx_rr                  = IW'(next_valid(3'(idx_q), valid_ext, NSRC));
    active_valid            = src_valid[idx_q];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|src_valid) begin
          idx_d   = idx_lowest;
          state_d = ST_RESTART;
        end
      end
      ST_RESTART: begin
        dwell_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        out_d = src_data[idx_q*WIDTH +: WIDTH];
        // A skip request or loss of the active source preempts dwell counting.
        if (next || !active_valid) begin
          state_d = ST_SWITCH;
        end else if (tick && !hold) begin
          if (dwell_q == DWELL - 8'd1) state_d = ST_SWITCH;
          else                         dwell_d = dwell_q + 8'd1;
        end
      end
      ST_SWITCH: begin
        if (|src_valid) begin
          idx_d   = idx_rr;
          state_d = ST_RESTART;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // LEDs go dark from the first cycle spent in IDLE.
    if (state_d == ST_IDLE) begin
      out_d   = '0;
      dwell_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    idx_onehot        = '0;
    idx_onehot[idx_q] = 1'b1;
    src_restart       = (state_q == ST_RESTART) ? idx_onehot : '0;
    src_enable        = (state_q == ST_RUN) ? idx_onehot : '0;
    src_tick          = (state_q == ST_RUN && tick) ? idx_onehot : '0;
  end

  assign active_idx = idx_q;
  assign out        = out_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Self-checking bench for led_pattern_sched: a cycle-level behavioural model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_led_pattern_sched;

  localparam int NSRC  = 4;
  localparam int WIDTH = 8;
  localparam int DEC   = 20;
  localparam int DW    = 3;

  localparam int P_IDLE    = 0;
  localparam int P_RESTART = 1;
  localparam int P_RUN     = 2;
  localparam int P_SWITCH  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] src_data = '0;
  logic [3:0]  src_valid = '0;
  logic        hold = 1'b0;
  logic        next = 1'b0;
  logic [3:0]  src_restart, src_enable, src_tick;
  logic [1:0]  active_idx;
  logic [7:0]  out;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: phase of the schedule, chosen source, ticks consumed in
  // the current dwell, cycles since the last reset edge and the LED value.
  int         m_phase, m_active, m_done, m_cyc;
  logic [7:0] m_out, m_nxt;
  bit         m_tick;

  always #5 clk = ~clk;

  led_pattern_sched #(
    .NSRC(NSRC), .WIDTH(WIDTH), .DECIMATION(20'd20), .DWELL(8'd3)
  ) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
    .hold(hold), .next(next), .src_restart(src_restart), .src_enable(src_enable),
    .src_tick(src_tick), .active_idx(active_idx), .out(out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_after(input int from, input logic [3:0] mask);
    for (int k = 1; k <= NSRC; k++) begin
      if (mask[(from + k) % NSRC]) return (from + k) % NSRC;
    end
    return from;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = P_IDLE; m_active = 0; m_out = '0; m_cyc = 0; m_done = 0;
    end else begin
      m_tick = (m_cyc % DEC) == DEC - 1;
      m_nxt  = m_out;
      case (m_phase)
        P_IDLE: if (src_valid != 0) begin
          m_active = rr_after(NSRC - 1, src_valid);
          m_phase  = P_RESTART;
        end
        P_RESTART: begin m_done = 0; m_phase = P_RUN; end
        P_RUN: begin
          m_nxt = src_data[m_active*WIDTH +: WIDTH];
          if (next || !src_valid[m_active]) m_phase = P_SWITCH;
          else if (m_tick && !hold) begin
            m_done++;
            if (m_done == DW) m_phase = P_SWITCH;
          end
        end
        default: begin
          if (src_valid == 0) m_phase = P_IDLE;
          else begin m_active = rr_after(m_active, src_valid); m_phase = P_RESTART; end
        end
      endcase
      m_out = (m_phase == P_IDLE) ? 8'h00 : m_nxt;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out", out, m_out);
      check("active_idx", active_idx, m_active);
      check("src_restart", src_restart, (m_phase == P_RESTART) ? (4'b1 << m_active) : 4'b0);
      check("src_enable", src_enable, (m_phase == P_RUN) ? (4'b1 << m_active) : 4'b0);
      check("src_tick", src_tick,
            (m_phase == P_RUN && (m_cyc % DEC) == DEC - 1) ? (4'b1 << m_active) : 4'b0);
    end
  end

  always @(negedge clk) begin
    #1 src_data = $urandom;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish within 500us");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic do_reset();
    reset = 1'b0; hold = 1'b0; next = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic wait_restart(input int budget, output int cycles, output logic [3:0] pulse);
    cycles = 0; pulse = '0;
    while (cycles < budget) begin
      step(); cycles++;
      if (src_restart != 0) begin pulse = src_restart; return; end
    end
    n_checks++; n_errors++;
    $display("FAIL wait_restart: got no restart pulse, expected one within %0d cycles", budget);
  endtask

  int         c, ticks, rsts;
  logic [3:0] p;
  logic [7:0] d;

  initial begin
    @(posedge clk); #1 chk_en = 1'b1;

    // 1: full rotation 0->1->2->3->0 at 60 cycles per source
    src_valid = 4'b1111; do_reset();
    wait_restart(50, c, p);
    check("t1_first_restart", p, 4'b0001);
    check("t1_first_idx", active_idx, 0);
    for (int i = 1; i <= 4; i++) begin
      step(5); d = src_data[((i - 1) % 4)*8 +: 8];
      step(); check("t1_out_lag", out, d);
      wait_restart(100, c, p);
      check("t1_rot_pulse", p, 4'b1 << (i % 4));
      check("t1_rot_period", c, 60 - 6);
    end

    // 2: nothing valid stays dark, then a single source keeps re-restarting
    src_valid = 4'b0000; do_reset();
    step(30);
    check("t2_idle_out", out, 0);
    check("t2_idle_enable", src_enable, 0);
    src_valid = 4'b0100;
    wait_restart(10, c, p);
    check("t2_restart2", p, 4'b0100);
    check("t2_idx2", active_idx, 2);
    wait_restart(100, c, p);
    check("t2_rerestart", p, 4'b0100);
    wait_restart(100, c, p);
    check("t2_rerestart_period", c, 60);

    // 3: manual skip over a sparse mask with wrap
    src_valid = 4'b1010; do_reset();
    wait_restart(50, c, p);
    check("t3_first", p, 4'b0010);
    step(5); next = 1'b1; step(); next = 1'b0;
    wait_restart(5, c, p);
    check("t3_skip_to3", active_idx, 3);
    step(5); next = 1'b1; step(); next = 1'b0;
    wait_restart(5, c, p);
    check("t3_wrap_to1", active_idx, 1);

    // 4: hold freezes rotation while ticks keep flowing
    src_valid = 4'b1111; do_reset();
    wait_restart(50, c, p);
    step(3); hold = 1'b1; ticks = 0; rsts = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (src_tick[0]) ticks++;
      if (src_restart != 0) rsts++;
    end
    check("t4_ticks_in_hold", ticks, 10);
    check("t4_no_rotation", rsts, 0);
    hold = 1'b0;
    wait_restart(62, c, p);
    check("t4_release_rotates", p, 4'b0010);

    // 5: losing the active source, then next coinciding with dwell expiry
    src_valid = 4'b1111; do_reset();
    wait_restart(50, c, p);
    step(10); src_valid = 4'b1110; step();
    check("t5_drop_switch", src_enable, 0);
    wait_restart(3, c, p);
    check("t5_drop_next_src", p, 4'b0010);
    src_valid = 4'b1111;
    c = 0;
    while (c < 100 && !(m_phase == P_RUN && m_done == DW - 1 && (m_cyc % DEC) == DEC - 1)) begin
      step(); c++;
    end
    check("t5_found_expiry", c < 100, 1);
    next = 1'b1; step(); next = 1'b0;
    check("t5_single_switch", src_enable, 0);
    wait_restart(3, c, p);
    check("t5_one_advance", active_idx, 2);

    // 6: reset in RESTART and in RUN
    src_valid = 4'b0110; do_reset();
    wait_restart(50, c, p);
    reset = 1'b0; step();
    check("t6_rst_restart", src_restart, 0);
    check("t6_rst_idx", active_idx, 0);
    reset = 1'b1;
    wait_restart(5, c, p);
    check("t6_relaunch1", p, 4'b0010);
    step(30); reset = 1'b0; step();
    check("t6_rst_out", out, 0);
    check("t6_rst_enable", src_enable, 0);
    check("t6_rst_tick", src_tick, 0);
    reset = 1'b1;
    wait_restart(5, c, p);
    check("t6_relaunch2", p, 4'b0010);

    // Randomised traffic, checked cycle-by-cycle against the model
    src_valid = 4'(($urandom % 15) + 1);
    for (int i = 0; i < 4000; i++) begin
      next = ($urandom % 25) == 0;
      if (($urandom % 40) == 0) hold = ~hold;
      if (($urandom % 150) == 0) src_valid = 4'($urandom);
      reset = ($urandom % 600) != 0;
      step();
    end
    reset = 1'b1; next = 1'b0; hold = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
